// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes: single-cycle logic/add/sub/slt
// and an iterative shift-add multiplier sharing one output register.
module alu_pipe #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             CarryIn,
  input  logic [3:0]       ALUOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Zero,
  output logic             Overflow
);

  localparam int MSB = WIDTH - 1;
  localparam int CW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

  state_t           state_r, state_next_s;
  logic [WIDTH-1:0] mcand_r, mplier_r, acc_r, acc_next_s;
  logic [CW-1:0]    count_r;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] op_res_s;
  logic             op_co_s, op_ov_s;
  logic             accept_s, mul_start_s, single_load_s, mul_done_s;
  logic [WIDTH-1:0] result_r;
  logic             out_valid_r, carry_r, zero_r, ovf_r;

  assign in_ready      = (state_r == ST_IDLE) && (!out_valid_r || out_ready);
  assign accept_s      = in_valid && in_ready;
  assign mul_start_s   = accept_s && (ALUOp == OP_MUL);
  assign single_load_s = accept_s && (ALUOp != OP_MUL);
  assign mul_done_s    = (state_r == ST_MUL) && (count_r == CW'(WIDTH - 1));

  assign out_valid = out_valid_r;
  assign Result    = result_r;
  assign CarryOut  = carry_r;
  assign Zero      = zero_r;
  assign Overflow  = ovf_r;

  // Single-cycle operation datapath; MUL and undefined opcodes yield zero here
  always_comb begin
    sum_s    = '0;
    op_res_s = '0;
    op_co_s  = 1'b0;
    op_ov_s  = 1'b0;
    case (ALUOp)
      OP_AND: op_res_s = a & b;
      OP_OR:  op_res_s = a | b;
      OP_NOR: op_res_s = ~(a | b);
      OP_ADD: begin
        sum_s    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, CarryIn};
        op_res_s = sum_s[WIDTH-1:0];
        op_co_s  = sum_s[WIDTH];
        op_ov_s  = (a[MSB] == b[MSB]) && (sum_s[MSB] != a[MSB]);
      end
      OP_SUB: begin
        // carry out of a + ~b + 1 is the no-borrow indication
        sum_s    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        op_res_s = sum_s[WIDTH-1:0];
        op_co_s  = sum_s[WIDTH];
        op_ov_s  = (a[MSB] != b[MSB]) && (sum_s[MSB] != a[MSB]);
      end
      OP_SLT: op_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: op_res_s = '0;
    endcase
  end

  // Shift-add accumulator step
  always_comb begin
    acc_next_s = acc_r;
    if (mplier_r[0]) begin
      acc_next_s = acc_r + mcand_r;
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (mul_start_s) state_next_s = ST_MUL;
        else             state_next_s = ST_IDLE;
      end
      ST_MUL: begin
        if (mul_done_s) state_next_s = ST_IDLE;
        else            state_next_s = ST_MUL;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_next_s;
  end

  // Multiplier operand, accumulator and iteration registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_r  <= '0;
      mplier_r <= '0;
      acc_r    <= '0;
      count_r  <= '0;
    end else if (mul_start_s) begin
      mcand_r  <= a;
      mplier_r <= b;
      acc_r    <= '0;
      count_r  <= '0;
    end else if (state_r == ST_MUL) begin
      acc_r    <= acc_next_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      count_r  <= count_r + CW'(1);
    end
  end

  // Output register: loads on completion, holds under backpressure
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      result_r    <= '0;
      carry_r     <= 1'b0;
      zero_r      <= 1'b0;
      ovf_r       <= 1'b0;
    end else if (single_load_s) begin
      out_valid_r <= 1'b1;
      result_r    <= op_res_s;
      carry_r     <= op_co_s;
      zero_r      <= (op_res_s == '0);
      ovf_r       <= op_ov_s;
    end else if (mul_done_s) begin
      out_valid_r <= 1'b1;
      result_r    <= acc_next_s;
      carry_r     <= 1'b0;
      zero_r      <= (acc_next_s == '0);
      ovf_r       <= 1'b0;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered successor to the datapath ALU. It keeps the established operand/opcode encoding (AND, OR, ADD, SUB, NOR), adds SLT and an iterative multi-cycle MUL, and produces Zero and Overflow flags. Operands and results move through valid/ready handshakes so the block can sit between pipeline stages of the datapath and stall them correctly.

## Interface
- WIDTH, 64, operand/result width in bits (≥ 2)
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operation request valid
- in_ready  output  1  block can accept a request this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- CarryIn  input  1  carry into ADD; ignored by all other ops
- ALUOp  input  4  opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1000 MUL, 1100 NOR
- out_valid  output  1  Result and flags valid
- out_ready  input  1  consumer accepts result
- Result  output  WIDTH  registered result
- CarryOut  output  1  registered carry/no-borrow
- Zero  output  1  registered, 1 when Result == 0
- Overflow  output  1  registered signed-overflow flag

## Operation
- Accept: in_valid && in_ready at a rising edge. Operands and opcode are sampled only on accept.
- in_ready = (state == IDLE) && (!out_valid || out_ready). It is combinational.
- Output register: loaded on completion and held stable while out_valid && !out_ready. out_valid clears on out_ready unless a new result loads in the same edge.
- ADD: a + b + CarryIn, mod 2^WIDTH.
  - CarryOut is the carry out of the MSB.
  - Overflow = (a[MSB] == b[MSB]) && (Result[MSB] != a[MSB]).
- SUB: a + ~b + 1. CarryIn is ignored.
  - CarryOut = 1 when there is no borrow (a ≥ b unsigned).
  - Overflow = (a[MSB] != b[MSB]) && (Result[MSB] != a[MSB]).
- SLT: Result = 1 if a < b signed, else 0. CarryOut = 0, Overflow = 0.
- AND, OR, NOR: bitwise. CarryOut = 0, Overflow = 0.
- MUL: low WIDTH bits of the unsigned product, computed by shift-add. CarryOut = 0, Overflow = 0.
- Undefined opcode: Result = 0, Zero = 1, CarryOut = 0, Overflow = 0, 1-cycle latency.
- Zero = (Result == 0) for every op.
- FSM states: IDLE and MUL.
  - IDLE → MUL on accept with ALUOp = 1000. This loads mcand = a, mplier = b, acc = 0, count = 0.
  - In MUL, each cycle:
    - If mplier[0] is set, acc += mcand.
    - mcand <<= 1; mplier >>= 1; count++.
  - On the iteration where count == WIDTH−1, the final acc loads into the output register, out_valid = 1, and the FSM returns to IDLE.
  - All other ops stay in IDLE and load the output register on the accept edge.

## Timing
- Reset (asynchronous, immediate): out_valid = 0, Result = 0, CarryOut = 0, Zero = 0, Overflow = 0, state = IDLE, count/acc/mcand/mplier = 0.
  - in_ready is therefore 1 while reset is asserted and after it is released, provided out_ready is irrelevant because out_valid = 0.
- Single-cycle ops: accepted at edge k → out_valid = 1 after edge k (latency 1).
  - Back-to-back accepts at one per cycle are allowed while out_ready = 1.
- MUL: accepted at edge k → in_ready = 0 after edges k … k+WIDTH−1 → out_valid = 1 after edge k+WIDTH.
  - in_ready returns to 1 in that same cycle if out_ready = 1.
- Because in_ready requires a free or draining output register, a completing op never overwrites an unconsumed result.
- Simultaneous drain and accept (out_valid && out_ready && in_valid, IDLE): the new single-cycle result loads on the same edge and out_valid stays 1.
- Reset during MUL: the operation is aborted and no result is produced. Outputs take reset values immediately.
- in_valid is ignored while in_ready = 0, so there is no queuing.

## Test plan
All scenarios instantiate WIDTH = 6.
- **Logic ops after reset:** a = 3F, b = 00, out_ready = 1.
  - AND → Result 00, Zero 1.
  - OR → 3F, Zero 0.
  - NOR → 00, Zero 1.
  - Each result has out_valid exactly 1 cycle after accept.
- **Add:**
  - a = 3F, b = 00, CarryIn = 1 → Result 00, CarryOut 1, Zero 1, Overflow 0.
  - a = 1F, b = 01, CarryIn = 0 → 20, CarryOut 0, Overflow 1.
- **Sub/SLT:**
  - SUB a = 05, b = 07 → 3E, CarryOut 0, Overflow 0.
  - SLT with the same operands → 01.
  - SUB a = 20, b = 01 → 1F, CarryOut 1, Overflow 1.
- **Mul:**
  - a = 07, b = 09 → Result 3F, out_valid exactly 6 cycles after accept, in_ready 0 throughout.
  - a = 10, b = 04 → 00, Zero 1.
- **Backpressure:** out_ready = 0, ADD a = 01, b = 01 accepted → Result 02 is held, in_ready = 0, and a second request (OR) is not accepted. Raise out_ready → OR is accepted on the same edge as the drain.
- **Reset mid-MUL:** assert reset 3 cycles after a MUL accept → immediately out_valid = 0, Result = 00. After release, in_ready = 1 and no stale result ever appears.
